// File: rtl/pmo_qbus_slave.sv
// QBUS slave for the PMo board: one I/O-page CSR (switch read / display write)
// driving the board LEDs. Never masters the bus; all R*/T* are active-high here.
module pmo_qbus_slave #(
  parameter logic [12:0] CSR_ADDR     = 13'o17570,
  parameter logic [15:0] SWITCH_VALUE = 16'o177777
) (
  input  logic        qclk,
  input  logic        reset_n,
  output logic        led_d8,
  output logic        led_d9,
  output logic        led_d10,
  output logic        led_d11,
  output logic        led_c12,
  output logic        led_d12,
  output logic        tp_b30,
  output logic        DALbe_L,
  output logic        DALtx,
  output logic        DALst,
  inout  wire  [21:0] ZDAL,
  inout  wire         ZBS7,
  inout  wire         ZWTBT,
  input  logic        RSYNC,
  input  logic        RDIN,
  input  logic        RDOUT,
  input  logic        RRPLY,
  input  logic        RREF,
  input  logic        RIRQ4,
  input  logic        RIRQ5,
  input  logic        RIRQ6,
  input  logic        RIRQ7,
  input  logic        RDMR,
  input  logic        RSACK,
  input  logic        RINIT,
  input  logic        RIAKI,
  input  logic        RDMGI,
  input  logic        RDCOK,
  input  logic        RPOK,
  output logic        TSYNC,
  output logic        TDIN,
  output logic        TDOUT,
  output logic        TRPLY,
  output logic        TREF,
  output logic        TIRQ4,
  output logic        TIRQ5,
  output logic        TIRQ6,
  output logic        TIRQ7,
  output logic        TDMR,
  output logic        TSACK,
  output logic        TIAKO,
  output logic        TDMGO
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_RD_LOAD  = 3'd2;
  localparam logic [2:0] S_RD_DRV   = 3'd3;
  localparam logic [2:0] S_RD_RPLY  = 3'd4;
  localparam logic [2:0] S_WR       = 3'd5;
  localparam logic [2:0] S_WAIT_END = 3'd6;

  logic [3:0]  meta_reg;
  logic [3:0]  sync_reg;
  logic        sync_s, din_s, dout_s, init_s;
  logic [23:0] addr_reg;   // {bs7, wtbt, dal[21:0]}
  logic        sel;
  logic [2:0]  state_reg;
  logic [15:0] display_reg;
  logic [15:0] wr_data;
  logic        trply_reg, dal_tx_reg, dalst_reg, dalbe_l_reg;
  logic        drive_en;

  // Two-flop synchronizers for the bus control lines the FSM acts on
  always_ff @(posedge qclk or negedge reset_n) begin
    if (!reset_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= {RINIT, RDOUT, RDIN, RSYNC};
      sync_reg <= meta_reg;
    end
  end

  assign sync_s = sync_reg[0];
  assign din_s  = sync_reg[1];
  assign dout_s = sync_reg[2];
  assign init_s = sync_reg[3];

  // Address tracks the bus while SYNC is negated and freezes once SYNC asserts
  always_ff @(posedge qclk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg <= '0;
    end else if (!dal_tx_reg && !RSYNC) begin
      addr_reg <= {ZBS7, ZWTBT, ZDAL};
    end
  end

  // addr bit 0 is the byte select, so the word compare skips it
  assign sel = addr_reg[23] && (addr_reg[12:1] == CSR_ADDR[12:1]);

  always_comb begin
    wr_data = display_reg;
    if (!addr_reg[22]) begin
      wr_data = ZDAL[15:0];
    end else if (addr_reg[0]) begin
      wr_data[15:8] = ZDAL[15:8];
    end else begin
      wr_data[7:0] = ZDAL[7:0];
    end
  end

  always_ff @(posedge qclk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      display_reg <= '0;
      trply_reg   <= 1'b0;
      dal_tx_reg  <= 1'b0;
      dalst_reg   <= 1'b0;
      dalbe_l_reg <= 1'b1;
    end else begin
      dalst_reg <= 1'b0;
      if (init_s || !sync_s) begin
        state_reg   <= S_IDLE;
        trply_reg   <= 1'b0;
        dal_tx_reg  <= 1'b0;
        dalbe_l_reg <= 1'b1;
        if (init_s) begin
          display_reg <= '0;
        end
      end else begin
        case (state_reg)
          S_IDLE: state_reg <= S_ADDR;
          S_ADDR: begin
            if (!sel) begin
              state_reg <= S_WAIT_END;
            end else if (din_s) begin
              state_reg  <= S_RD_LOAD;
              dal_tx_reg <= 1'b1;
              dalst_reg  <= 1'b1;
            end else if (dout_s) begin
              state_reg   <= S_WR;
              trply_reg   <= 1'b1;
              display_reg <= wr_data;
            end
          end
          S_RD_LOAD: begin
            state_reg   <= S_RD_DRV;
            dalbe_l_reg <= 1'b0;
          end
          S_RD_DRV: begin
            state_reg <= S_RD_RPLY;
            trply_reg <= 1'b1;
          end
          S_RD_RPLY: begin
            if (!din_s) begin
              state_reg   <= S_ADDR;
              trply_reg   <= 1'b0;
              dalbe_l_reg <= 1'b1;
              dal_tx_reg  <= 1'b0;
            end
          end
          S_WR: begin
            if (!dout_s) begin
              state_reg <= S_ADDR;
              trply_reg <= 1'b0;
            end
          end
          S_WAIT_END: state_reg <= S_WAIT_END;
          default:    state_reg <= S_IDLE;
        endcase
      end
    end
  end

  // Raw SYNC gating keeps the pins quiet the instant the master drops SYNC
  assign drive_en = dal_tx_reg && RSYNC && sel;
  assign ZDAL  = drive_en ? {6'b0, SWITCH_VALUE} : 22'bz;
  assign ZBS7  = drive_en ? 1'b0 : 1'bz;
  assign ZWTBT = drive_en ? 1'b0 : 1'bz;

  assign DALtx   = dal_tx_reg;
  assign DALst   = dalst_reg;
  assign DALbe_L = dalbe_l_reg;
  assign TRPLY   = trply_reg;
  assign led_c12 = trply_reg;
  assign led_d8  = display_reg[0];
  assign led_d9  = display_reg[1];
  assign led_d10 = display_reg[2];
  assign led_d11 = display_reg[3];
  assign led_d12 = display_reg[4];
  assign tp_b30  = (state_reg != S_IDLE) && sel;

  assign TSYNC = 1'b0;
  assign TDIN  = 1'b0;
  assign TDOUT = 1'b0;
  assign TREF  = 1'b0;
  assign TIRQ4 = 1'b0;
  assign TIRQ5 = 1'b0;
  assign TIRQ6 = 1'b0;
  assign TIRQ7 = 1'b0;
  assign TDMR  = 1'b0;
  assign TSACK = 1'b0;
  assign TIAKO = 1'b0;
  assign TDMGO = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{RRPLY, RREF, RIRQ4, RIRQ5, RIRQ6, RIRQ7, RDMR, RSACK,
                       RIAKI, RDMGI, RDCOK, RPOK, addr_reg[21:13], display_reg[15:5]};

endmodule

// File: tb/tb_pmo_qbus_slave.sv
// Directed bench for pmo_qbus_slave: table of DATI/DATO(B) cycles plus
// hand sequences for INIT, DATIO and reset in the middle of a read.
`timescale 1ns/1ps
module tb_pmo_qbus_slave;

  logic qclk = 1'b0;
  logic reset_n;
  logic RSYNC, RDIN, RDOUT, RINIT;
  logic led_d8, led_d9, led_d10, led_d11, led_c12, led_d12, tp_b30;
  logic DALbe_L, DALtx, DALst;
  logic TSYNC, TDIN, TDOUT, TRPLY, TREF, TIRQ4, TIRQ5, TIRQ6, TIRQ7;
  logic TDMR, TSACK, TIAKO, TDMGO;

  wire [21:0] zdal;
  wire        zbs7, zwtbt;
  logic        tb_drv;
  logic [21:0] tb_zdal;
  logic        tb_bs7, tb_wtbt;
  assign zdal  = tb_drv ? tb_zdal : 22'bz;
  assign zbs7  = tb_drv ? tb_bs7  : 1'bz;
  assign zwtbt = tb_drv ? tb_wtbt : 1'bz;

  always #25 qclk = ~qclk;  // 20 MHz

  pmo_qbus_slave dut (
    .qclk(qclk), .reset_n(reset_n),
    .led_d8(led_d8), .led_d9(led_d9), .led_d10(led_d10), .led_d11(led_d11),
    .led_c12(led_c12), .led_d12(led_d12), .tp_b30(tp_b30),
    .DALbe_L(DALbe_L), .DALtx(DALtx), .DALst(DALst),
    .ZDAL(zdal), .ZBS7(zbs7), .ZWTBT(zwtbt),
    .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT), .RRPLY(1'b0), .RREF(1'b0),
    .RIRQ4(1'b0), .RIRQ5(1'b0), .RIRQ6(1'b0), .RIRQ7(1'b0), .RDMR(1'b0),
    .RSACK(1'b0), .RINIT(RINIT), .RIAKI(1'b0), .RDMGI(1'b0), .RDCOK(1'b1),
    .RPOK(1'b1),
    .TSYNC(TSYNC), .TDIN(TDIN), .TDOUT(TDOUT), .TRPLY(TRPLY), .TREF(TREF),
    .TIRQ4(TIRQ4), .TIRQ5(TIRQ5), .TIRQ6(TIRQ6), .TIRQ7(TIRQ7), .TDMR(TDMR),
    .TSACK(TSACK), .TIAKO(TIAKO), .TDMGO(TDMGO)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          wr;
    bit          bs7;
    bit          wtbt;
    logic [21:0] addr;
    logic [21:0] wdata;
    bit          reply;
    logic [4:0]  leds;
  } vec_t;
  vec_t vecs[10];

  function automatic logic [4:0] leds();
    return {led_d12, led_d11, led_d10, led_d9, led_d8};
  endfunction

  function automatic logic [11:0] tbus();
    return {TSYNC, TDIN, TDOUT, TREF, TIRQ4, TIRQ5, TIRQ6, TIRQ7, TDMR, TSACK, TIAKO, TDMGO};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0o expected %0o", nm, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge qclk);
  endtask

  task automatic addr_phase(input logic bs7, input logic wtbt, input logic [21:0] a);
    tb_drv = 1'b1; tb_zdal = a; tb_bs7 = bs7; tb_wtbt = wtbt;
    RSYNC = 1'b0;
    clk_n(2);
    RSYNC = 1'b1;
    clk_n(2);
  endtask

  task automatic do_read(input string nm, input bit exp_reply);
    int cnt; int st; bit seen; bit bad;
    tb_drv = 1'b0;
    RDIN = 1'b1;
    cnt = 0; st = 0; seen = 0; bad = 0;
    if (exp_reply) begin
      while (!seen && cnt < 8) begin
        clk_n(1); cnt++;
        if (DALst) st++;
        if (TRPLY) seen = 1;
      end
      check({nm, " rply<=250ns"}, 32'(seen && cnt <= 5), 1);
      check({nm, " rdata"}, 32'(zdal), 32'o177777);
      check({nm, " dal ctl {tx,be_L,bs7,wtbt,tp}"},
            {27'd0, DALtx, DALbe_L, zbs7, zwtbt, tp_b30}, 32'b10001);
      check({nm, " dalst pulses"}, 32'(st), 1);
      check({nm, " T* idle"}, 32'(tbus()), 0);
      RDIN = 1'b0;
      cnt = 0;
      while (TRPLY && cnt < 8) begin clk_n(1); cnt++; end
      check({nm, " rply off<=150ns"}, 32'(!TRPLY && cnt <= 3), 1);
      check({nm, " released {tx,be_L}"}, {30'd0, DALtx, DALbe_L}, 32'b01);
    end else begin
      repeat (200) begin
        clk_n(1);
        if (TRPLY || DALtx || DALst || tp_b30) bad = 1;
      end
      check({nm, " no reply/drive 10us"}, 32'(bad), 0);
      RDIN = 1'b0;
    end
  endtask

  task automatic do_write(input string nm, input logic [21:0] d, input bit exp_reply);
    int cnt; bit seen; bit bad;
    tb_drv = 1'b1; tb_zdal = d;
    RDOUT = 1'b1;
    cnt = 0; seen = 0; bad = 0;
    if (exp_reply) begin
      while (!seen && cnt < 8) begin
        clk_n(1); cnt++;
        if (DALtx) bad = 1;
        if (TRPLY) seen = 1;
      end
      check({nm, " wr rply"}, 32'(seen && cnt <= 5 && !bad), 1);
      RDOUT = 1'b0;
      cnt = 0;
      while (TRPLY && cnt < 8) begin clk_n(1); cnt++; end
      check({nm, " wr rply off"}, 32'(!TRPLY && cnt <= 3), 1);
    end else begin
      repeat (200) begin
        clk_n(1);
        if (TRPLY || DALtx || tp_b30) bad = 1;
      end
      check({nm, " wr no reply 10us"}, 32'(bad), 0);
      RDOUT = 1'b0;
    end
  endtask

  task automatic end_cycle(input string nm);
    RSYNC = 1'b0;
    tb_drv = 1'b0;
    clk_n(3);
    check({nm, " idle {rply,tx,be_L,tp}"}, {28'd0, TRPLY, DALtx, DALbe_L, tp_b30}, 32'b0010);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{0, 1, 0, 22'o17777570, 22'o0,      1, 5'b00000};
    vecs[1] = '{1, 1, 0, 22'o17777570, 22'o054321, 1, 5'b10001};
    vecs[2] = '{1, 1, 1, 22'o17777571, 22'o052400, 1, 5'b10001};
    vecs[3] = '{0, 0, 0, 22'o00777570, 22'o0,      0, 5'b10001};
    vecs[4] = '{0, 1, 0, 22'o17777400, 22'o0,      0, 5'b10001};
    vecs[5] = '{1, 1, 1, 22'o17777570, 22'o177412, 1, 5'b01010};
    vecs[6] = '{1, 0, 0, 22'o00777570, 22'o000037, 0, 5'b01010};
    vecs[7] = '{1, 1, 0, 22'o17777570, 22'o000037, 1, 5'b11111};
    vecs[8] = '{1, 1, 1, 22'o17777571, 22'o000000, 1, 5'b11111};
    vecs[9] = '{0, 1, 0, 22'o17777570, 22'o0,      1, 5'b11111};

    reset_n = 1'b0; RSYNC = 1'b0; RDIN = 1'b0; RDOUT = 1'b0; RINIT = 1'b0;
    tb_drv = 1'b0; tb_zdal = '0; tb_bs7 = 1'b0; tb_wtbt = 1'b0;
    clk_n(3);
    check("reset {rply,tx,st,be_L,tp,c12}",
          {26'd0, TRPLY, DALtx, DALst, DALbe_L, tp_b30, led_c12}, 32'b000100);
    check("reset leds", 32'(leds()), 0);
    check("reset T*", 32'(tbus()), 0);
    reset_n = 1'b1;
    clk_n(3);

    for (int i = 0; i < 10; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      addr_phase(vecs[i].bs7, vecs[i].wtbt, vecs[i].addr);
      if (vecs[i].wr) do_write(nm, vecs[i].wdata, vecs[i].reply);
      else            do_read(nm, vecs[i].reply);
      end_cycle(nm);
      check({nm, " leds"}, 32'(leds()), 32'(vecs[i].leds));
      $display("[TB] vec %0d %s addr=%0o bs7=%0d wtbt=%0d data=%0o leds=%b",
               i, vecs[i].wr ? "DATO" : "DATI", vecs[i].addr, vecs[i].bs7,
               vecs[i].wtbt, vecs[i].wdata, leds());
    end

    // INIT clears the display
    RINIT = 1'b1; clk_n(4); RINIT = 1'b0; clk_n(3);
    check("init leds", 32'(leds()), 0);
    $display("[TB] INIT pulse leds=%b", leds());

    // DATIO: read then write inside a single SYNC
    addr_phase(1'b1, 1'b0, 22'o17777570);
    do_read("datio", 1'b1);
    do_write("datio", 22'o054545, 1'b1);
    end_cycle("datio");
    check("datio leds", 32'(leds()), 32'b00101);
    $display("[TB] DATIO leds=%b", leds());

    // Asynchronous reset while replying to a read
    addr_phase(1'b1, 1'b0, 22'o17777570);
    tb_drv = 1'b0;
    RDIN = 1'b1;
    cnt = 0;
    while (!TRPLY && cnt < 10) begin clk_n(1); cnt++; end
    check("midrd rply before reset", 32'(TRPLY), 1);
    reset_n = 1'b0;
    #1;
    check("midrd {rply,tx,st,be_L,tp}",
          {27'd0, TRPLY, DALtx, DALst, DALbe_L, tp_b30}, 32'b00010);
    check("midrd leds", 32'(leds()), 0);
    $display("[TB] reset mid-read rply=%0d tx=%0d be_L=%0d", TRPLY, DALtx, DALbe_L);
    RDIN = 1'b0; RSYNC = 1'b0;
    clk_n(2);
    reset_n = 1'b1;
    clk_n(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
